// File: rtl/biquad_sequencer.sv
// rtl/biquad_sequencer.sv - time-multiplexed direct-form-I biquad over CHANNELS on one shared MAC
// Optional feature macro: BIQUAD_SAT_EN (saturating output plus sticky clip port).
module biquad_sequencer #(
    parameter int CHANNELS = 2,
    parameter int DW       = 16,
    parameter int CW       = 32,
    parameter int ACCW     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CHANNELS*DW-1:0] in_frame,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CHANNELS*DW-1:0] out_frame,
    input  logic                   coef_wr,
    input  logic [2:0]             coef_sel,
    input  logic [CW-1:0]          coef_data,
    input  logic                   coef_commit
`ifdef BIQUAD_SAT_EN
    ,
    output logic                   clip
`endif
);
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PW  = CW + DW;
    localparam logic [CHW-1:0] CH_LAST = CHW'(CHANNELS - 1);
    localparam logic [CW-1:0] COEF_ONE = CW'(64'd1 << 30);
    localparam logic [4:0][CW-1:0] BANK_RESET = {{(4*CW){1'b0}}, COEF_ONE};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_OUT} state_t;
    state_t state_q, state_d;

    logic [CHW-1:0]              ch_q, ch_d;
    logic [2:0]                  tap_q, tap_d;
    logic [ACCW-1:0]             acc_q, acc_d;
    logic [CHANNELS-1:0][DW-1:0] frame_q, frame_d, out_q, out_d;
    logic [CHANNELS-1:0][DW-1:0] x1_q, x1_d, x2_q, x2_d, y1_q, y1_d, y2_q, y2_d;
    logic [4:0][CW-1:0]          shadow_q, shadow_d, active_q, active_d;
    logic                        pending_q, pending_d;
    logic                        accept, bank_load;
    logic signed [CW-1:0]        mac_coef;
    logic signed [DW-1:0]        mac_samp;
    logic signed [PW-1:0]        mac_prod;
    logic [DW-1:0]               y_new;
`ifdef BIQUAD_SAT_EN
    logic                        clip_q, clip_d;
    logic                        y_ovf;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_MAC;
            S_MAC:   if (tap_q == 3'd4) state_d = S_WRITE;
            S_WRITE: state_d = (ch_q == CH_LAST) ? S_OUT : S_MAC;
            S_OUT:   if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) && !reset;
        out_valid = (state_q == S_OUT);
    end

    assign out_frame = out_q;
    assign accept    = in_valid && in_ready;
    // The active bank only moves while idle, so a frame in flight never sees a mixed set.
    assign bank_load = (state_q == S_IDLE) && pending_q;

    always_comb begin
        case (tap_q)
            3'd0:    begin mac_coef = active_q[0]; mac_samp = frame_q[ch_q]; end
            3'd1:    begin mac_coef = active_q[1]; mac_samp = x1_q[ch_q];    end
            3'd2:    begin mac_coef = active_q[2]; mac_samp = x2_q[ch_q];    end
            3'd3:    begin mac_coef = active_q[3]; mac_samp = y1_q[ch_q];    end
            default: begin mac_coef = active_q[4]; mac_samp = y2_q[ch_q];    end
        endcase
        mac_prod = mac_coef * mac_samp;

`ifdef BIQUAD_SAT_EN
        y_ovf = acc_q[ACCW-1:30+DW-1] != {(ACCW-30-DW+1){acc_q[ACCW-1]}};
        if (y_ovf) y_new = acc_q[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else       y_new = acc_q[30 +: DW];
        clip_d = clip_q || ((state_q == S_WRITE) && y_ovf);
`else
        y_new = acc_q[30 +: DW];
`endif

        ch_d      = ch_q;
        tap_d     = tap_q;
        acc_d     = acc_q;
        frame_d   = frame_q;
        out_d     = out_q;
        x1_d      = x1_q;
        x2_d      = x2_q;
        y1_d      = y1_q;
        y2_d      = y2_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = (bank_load ? 1'b0 : pending_q) | coef_commit;

        if (coef_wr && (coef_sel < 3'd5)) shadow_d[coef_sel] = coef_data;
        if (bank_load) active_d = shadow_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    frame_d = in_frame;
                    ch_d    = '0;
                    tap_d   = '0;
                end
            end
            S_MAC: begin
                acc_d = ((tap_q == 3'd0) ? '0 : acc_q) + {{(ACCW-PW){mac_prod[PW-1]}}, mac_prod};
                tap_d = tap_q + 3'd1;
            end
            S_WRITE: begin
                out_d[ch_q] = y_new;
                x2_d[ch_q]  = x1_q[ch_q];
                x1_d[ch_q]  = frame_q[ch_q];
                y2_d[ch_q]  = y1_q[ch_q];
                y1_d[ch_q]  = y_new;
                if (ch_q != CH_LAST) begin
                    ch_d  = ch_q + 1'b1;
                    tap_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch_q      <= '0;
            tap_q     <= '0;
            acc_q     <= '0;
            frame_q   <= '0;
            out_q     <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            y1_q      <= '0;
            y2_q      <= '0;
            shadow_q  <= BANK_RESET;
            active_q  <= BANK_RESET;
            pending_q <= 1'b0;
        end else begin
            ch_q      <= ch_d;
            tap_q     <= tap_d;
            acc_q     <= acc_d;
            frame_q   <= frame_d;
            out_q     <= out_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            y1_q      <= y1_d;
            y2_q      <= y2_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

`ifdef BIQUAD_SAT_EN
    always_ff @(posedge clk) begin
        if (reset) clip_q <= 1'b0;
        else       clip_q <= clip_d;
    end

    assign clip = clip_q;
`endif

endmodule

// File: tb/tb_biquad_sequencer.sv
// tb/tb_biquad_sequencer.sv - randomized self-checking bench for biquad_sequencer against a frame-level model
module tb_biquad_sequencer;
    localparam int CHANNELS = 2;
    localparam int DW       = 16;
    localparam int CW       = 32;
    localparam int FW       = CHANNELS * DW;
`ifdef BIQUAD_SAT_EN
    localparam longint WRAP_EXP = 32767;
`else
    localparam longint WRAP_EXP = -5537;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [FW-1:0] in_frame = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [FW-1:0] out_frame;
    logic          coef_wr = 1'b0;
    logic [2:0]    coef_sel = '0;
    logic [CW-1:0] coef_data = '0;
    logic          coef_commit = 1'b0;
`ifdef BIQUAD_SAT_EN
    logic          clip;
`endif

    always #5 clk = ~clk;

    biquad_sequencer #(.CHANNELS(CHANNELS), .DW(DW), .CW(CW), .ACCW(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_frame   (in_frame),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_frame  (out_frame),
        .coef_wr    (coef_wr),
        .coef_sel   (coef_sel),
        .coef_data  (coef_data),
        .coef_commit(coef_commit)
`ifdef BIQUAD_SAT_EN
        ,
        .clip       (clip)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic signed [CW-1:0] m_shd [5];
    logic signed [CW-1:0] m_act [5];
    bit                   m_pend;
    bit                   m_clip;
    logic signed [DW-1:0] m_x1 [CHANNELS];
    logic signed [DW-1:0] m_x2 [CHANNELS];
    logic signed [DW-1:0] m_y1 [CHANNELS];
    logic signed [DW-1:0] m_y2 [CHANNELS];

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [FW-1:0] mk(input int a, input int b);
        return {16'(b), 16'(a)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            m_shd[i] = (i == 0) ? 32'sh4000_0000 : 32'sd0;
            m_act[i] = m_shd[i];
        end
        m_pend = 0;
        m_clip = 0;
        for (int c = 0; c < CHANNELS; c++) begin
            m_x1[c] = 0; m_x2[c] = 0; m_y1[c] = 0; m_y2[c] = 0;
        end
    endtask

    // One filtered frame: plain 64-bit sum of products, floor-shift by 30, then wrap or clamp.
    function automatic logic [FW-1:0] model_frame(input logic [FW-1:0] f);
        logic [FW-1:0]        r;
        logic signed [DW-1:0] x0, y;
        longint               acc, q;
        r = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            x0  = f[c*DW +: DW];
            acc = longint'(m_act[0]) * longint'(x0)
                + longint'(m_act[1]) * longint'(m_x1[c])
                + longint'(m_act[2]) * longint'(m_x2[c])
                + longint'(m_act[3]) * longint'(m_y1[c])
                + longint'(m_act[4]) * longint'(m_y2[c]);
            q = acc >>> 30;
`ifdef BIQUAD_SAT_EN
            if (q > 32767) begin y = 16'sd32767; m_clip = 1; end
            else if (q < -32768) begin y = -16'sd32768; m_clip = 1; end
            else y = q[DW-1:0];
`else
            y = q[DW-1:0];
`endif
            r[c*DW +: DW] = y;
            m_x2[c] = m_x1[c]; m_x1[c] = x0;
            m_y2[c] = m_y1[c]; m_y1[c] = y;
        end
        return r;
    endfunction

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic coef_write(input int sel, input logic [CW-1:0] data);
        @(negedge clk);
        coef_wr = 1'b1; coef_sel = 3'(sel); coef_data = data;
        @(negedge clk);
        coef_wr = 1'b0;
        if (sel < 5) m_shd[sel] = data;
    endtask

    task automatic commit_idle();
        @(negedge clk);
        coef_commit = 1'b1;
        @(negedge clk);
        coef_commit = 1'b0;
        @(negedge clk);
        m_act = m_shd;
        m_pend = 0;
    endtask

    task automatic run_frame(input logic [FW-1:0] f, input int hold, input bit mid,
                             input int msel, input logic [CW-1:0] mdata,
                             output logic [FW-1:0] got);
        logic [FW-1:0] exp, held;
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_frame = f;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        check("accept_wait", in_ready, 1);
        exp = model_frame(f);
        @(negedge clk);
        in_valid = 1'b0; in_frame = FW'({$urandom, $urandom});
        n = 1;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
            coef_wr     = mid && (n == 3);
            coef_commit = mid && (n == 3);
            coef_sel    = 3'(msel);
            coef_data   = mdata;
        end
        coef_wr = 1'b0; coef_commit = 1'b0;
        if (mid) begin
            if (msel < 5) m_shd[msel] = mdata;
            m_pend = 1;
        end
        check("latency", n, 13);
        for (int c = 0; c < CHANNELS; c++)
            check($sformatf("out_ch%0d", c), longint'($signed(out_frame[c*DW +: DW])),
                  longint'($signed(exp[c*DW +: DW])));
`ifdef BIQUAD_SAT_EN
        check("clip", clip, m_clip);
`endif
        held = out_frame;
        if (hold > 0) begin
            in_valid = 1'b1; in_frame = FW'({$urandom, $urandom});
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_frame", out_frame, held);
            check("stall_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("ov_drop", out_valid, 0);
        check("idle_ready", in_ready, 1);
        if (m_pend) begin m_act = m_shd; m_pend = 0; end
        got = held;
    endtask

    initial begin
        logic [FW-1:0] got;
        model_reset();

        do_reset(3);
        check("rst_out_frame", out_frame, 0);
        @(negedge clk);
        check("post_rst_ready", in_ready, 1);

        run_frame(mk(1000, -2000), 0, 0, 0, '0, got);
        check("pass_ch0", $signed(got[15:0]), 1000);
        check("pass_ch1", $signed(got[31:16]), -2000);

        do_reset(2);
        coef_write(0, 32'h2000_0000);
        coef_write(1, 32'h2000_0000);
        commit_idle();
        run_frame(mk(100, -40), 0, 0, 0, '0, got);
        check("half_f1_ch0", $signed(got[15:0]), 50);
        check("half_f1_ch1", $signed(got[31:16]), -20);
        run_frame(mk(300, 60), 1, 0, 0, '0, got);
        check("half_f2_ch0", $signed(got[15:0]), 200);
        check("half_f2_ch1", $signed(got[31:16]), 10);

        do_reset(2);
        coef_write(3, 32'h2000_0000);
        commit_idle();
        run_frame(mk(1024, 0), 0, 0, 0, '0, got);
        check("imp0", $signed(got[15:0]), 1024);
        run_frame(mk(0, 0), 0, 0, 0, '0, got);
        check("imp1", $signed(got[15:0]), 512);
        run_frame(mk(0, 0), 0, 0, 0, '0, got);
        check("imp2", $signed(got[15:0]), 256);
        run_frame(mk(0, 0), 0, 0, 0, '0, got);
        check("imp3", $signed(got[15:0]), 128);

        run_frame(mk(0, 0), 0, 1, 3, 32'h0, got);
        check("mid_old_bank", $signed(got[15:0]), 64);
        run_frame(mk(0, 0), 0, 0, 0, '0, got);
        check("mid_new_bank", $signed(got[15:0]), 0);

        coef_write(0, 32'h7fff_ffff);
        commit_idle();
        run_frame(mk(30000, 0), 0, 0, 0, '0, got);
        check("wrap_ch0", $signed(got[15:0]), WRAP_EXP);

        run_frame(mk(123, -456), 20, 0, 0, '0, got);

        @(negedge clk);
        in_valid = 1'b1; in_frame = mk(5000, -5000);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        do_reset(2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("rst_mid_no_out", out_valid, 0);
        end
        coef_write(0, 32'h2000_0000);
        coef_write(1, 32'h2000_0000);
        commit_idle();
        run_frame(mk(400, -600), 0, 0, 0, '0, got);
        check("rst_hist_ch0", $signed(got[15:0]), 200);
        check("rst_hist_ch1", $signed(got[31:16]), -300);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) coef_write($urandom_range(0, 7), $urandom);
                if ($urandom_range(0, 1) == 1) commit_idle();
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_frame(FW'({$urandom, $urandom}), $urandom_range(0, 3),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom, got);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
